// File: rtl/anim_pkg.sv
// anim_pkg: shared types and default constants for the Iori animation sequencer.
//   char_state_t  - 8-bit animation state code, shared with sprite stage and game logic
//   *_DEF         - default frame counts, hold length and strike frame
package anim_pkg;

    typedef enum logic [7:0] {
        ST_STAND   = 8'd0,
        ST_ATTACK  = 8'd1,
        ST_MOVEL   = 8'd2,
        ST_MOVER   = 8'd3,
        ST_DEFENSE = 8'd4,
        ST_HURT    = 8'd5
    } char_state_t;

    localparam int unsigned FRAME_W            = 8;
    localparam int unsigned HOLD_W             = 8;

    localparam int unsigned FRAME_HOLD_DEF     = 6;
    localparam int unsigned N_STAND_DEF        = 9;
    localparam int unsigned N_FORWARD_DEF      = 10;
    localparam int unsigned N_BACKWARD_DEF     = 9;
    localparam int unsigned N_ATTACK_DEF       = 6;
    localparam int unsigned N_DEFENSE_DEF      = 1;
    localparam int unsigned N_HURT_DEF         = 5;
    localparam int unsigned ATTACK_HIT_FRM_DEF = 3;

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: frame_clk rising-edge detector plus per-frame hold counter.
//   clk_i, rst_i   - system clock, async active-high reset
//   frame_clk_i    - frame clock level (Clk domain)
//   clr_i          - animation state is changing on this tick; restart hold count
//   tick_c_o       - one Clk high per frame_clk rising edge (combinational)
//   adv_c_o        - tick on which the current animation frame should advance
module frame_tick_gen
    import anim_pkg::*;
#(
    parameter int unsigned FRAME_HOLD = FRAME_HOLD_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic frame_clk_i,
    input  logic clr_i,
    output logic tick_c_o,
    output logic adv_c_o
);

    logic              frame_clk_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;

    assign tick_c_o = frame_clk_i & ~frame_clk_q;
    // A state change wins over an advance: the new animation starts from a fresh hold.
    assign adv_c_o  = tick_c_o & ~clr_i & (hold_q == HOLD_W'(FRAME_HOLD - 1));

    // Hold counter only moves on ticks.
    always_comb begin
        hold_d = hold_q;
        if (tick_c_o) begin
            if (clr_i || adv_c_o) begin
                hold_d = '0;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_clk_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            frame_clk_q <= frame_clk_i;
            hold_q      <= hold_d;
        end
    end

endmodule

// File: rtl/iori_anim_ctrl.sv
// iori_anim_ctrl: animation sequencer for character 2 (Iori), feeding the sprite ROM stage.
//   Clk, Reset       - 50 MHz clock, async active-high reset
//   frame_clk        - ~60 Hz frame clock level; rising edge is one tick
//   key_*            - decoded held player inputs
//   hit              - 1-Clk strike pulse from collision logic
//   character2_state - registered animation state code
//   frame_num        - registered frame index, always < frame count of the state
//   attack_strike    - pulse when the attack reaches its strike frame
//   hit_blocked      - pulse when a pending hit is absorbed by defense
//   anim_done        - pulse when an attack or hurt one-shot completes
module iori_anim_ctrl
    import anim_pkg::*;
#(
    parameter int unsigned FRAME_HOLD     = FRAME_HOLD_DEF,
    parameter int unsigned N_STAND        = N_STAND_DEF,
    parameter int unsigned N_FORWARD      = N_FORWARD_DEF,
    parameter int unsigned N_BACKWARD     = N_BACKWARD_DEF,
    parameter int unsigned N_ATTACK       = N_ATTACK_DEF,
    parameter int unsigned N_DEFENSE      = N_DEFENSE_DEF,
    parameter int unsigned N_HURT         = N_HURT_DEF,
    parameter int unsigned ATTACK_HIT_FRM = ATTACK_HIT_FRM_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               key_attack,
    input  logic               key_defend,
    input  logic               hit,
    output logic [FRAME_W-1:0] frame_num,
    output logic [7:0]         character2_state,
    output logic               attack_strike,
    output logic               hit_blocked,
    output logic               anim_done
);

    char_state_t        state_q, state_d, req_c;
    logic [FRAME_W-1:0] frame_q, frame_d, n_cur_c;
    logic               hit_pend_q, hit_pend_d;
    logic               strike_q, strike_d;
    logic               blocked_q, blocked_d;
    logic               done_q, done_d;
    logic               hit_eff_c, tick_c, adv_c, clr_c, oneshot_c;

    frame_tick_gen #(
        .FRAME_HOLD (FRAME_HOLD)
    ) u_tick (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .frame_clk_i (frame_clk),
        .clr_i       (clr_c),
        .tick_c_o    (tick_c),
        .adv_c_o     (adv_c)
    );

    // A hit in the same Clk as the tick is consumed by that tick.
    assign hit_eff_c = hit_pend_q | hit;
    assign oneshot_c = (state_q == ST_ATTACK) || (state_q == ST_HURT);
    assign clr_c     = tick_c & (req_c != state_q);

    // Frame count of the current animation.
    always_comb begin
        n_cur_c = FRAME_W'(N_STAND);
        case (state_q)
            ST_STAND:   n_cur_c = FRAME_W'(N_STAND);
            ST_ATTACK:  n_cur_c = FRAME_W'(N_ATTACK);
            ST_MOVEL:   n_cur_c = FRAME_W'(N_FORWARD);
            ST_MOVER:   n_cur_c = FRAME_W'(N_BACKWARD);
            ST_DEFENSE: n_cur_c = FRAME_W'(N_DEFENSE);
            ST_HURT:    n_cur_c = FRAME_W'(N_HURT);
            default:    n_cur_c = FRAME_W'(N_STAND);
        endcase
    end

    // Requested state on a tick, before one-shot completion.
    always_comb begin
        req_c = state_q;
        if (hit_eff_c && (state_q == ST_DEFENSE)) begin
            req_c = ST_DEFENSE;
        end else if (hit_eff_c && (state_q != ST_HURT)) begin
            req_c = ST_HURT;
        end else if (oneshot_c) begin
            req_c = state_q;
        end else if (key_attack) begin
            req_c = ST_ATTACK;
        end else if (key_defend) begin
            req_c = ST_DEFENSE;
        end else if (key_left && !key_right) begin
            req_c = ST_MOVEL;
        end else if (key_right && !key_left) begin
            req_c = ST_MOVER;
        end else begin
            req_c = ST_STAND;
        end
    end

    // Next state, frame index and event pulses.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        hit_pend_d = hit_eff_c;
        strike_d   = 1'b0;
        blocked_d  = 1'b0;
        done_d     = 1'b0;
        if (tick_c) begin
            hit_pend_d = 1'b0;
            if (hit_eff_c && (state_q == ST_DEFENSE)) begin
                blocked_d = 1'b1;
            end
            if (req_c != state_q) begin
                state_d = req_c;
                frame_d = '0;
            end else if (adv_c) begin
                if (frame_q == n_cur_c - FRAME_W'(1)) begin
                    frame_d = '0;
                    if (oneshot_c) begin
                        state_d = ST_STAND;
                        done_d  = 1'b1;
                    end
                end else begin
                    frame_d = frame_q + FRAME_W'(1);
                    if ((state_q == ST_ATTACK) &&
                        (frame_q == FRAME_W'(ATTACK_HIT_FRM) - FRAME_W'(1))) begin
                        strike_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_STAND;
            frame_q    <= '0;
            hit_pend_q <= 1'b0;
            strike_q   <= 1'b0;
            blocked_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            hit_pend_q <= hit_pend_d;
            strike_q   <= strike_d;
            blocked_q  <= blocked_d;
            done_q     <= done_d;
        end
    end

    assign character2_state = state_q;
    assign frame_num        = frame_q;
    assign attack_strike    = strike_q;
    assign hit_blocked      = blocked_q;
    assign anim_done        = done_q;

endmodule

// File: tb/tb_iori_anim_ctrl.sv
// tb_iori_anim_ctrl: directed self-checking bench for iori_anim_ctrl.
module tb_iori_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       key_attack = 1'b0;
    logic       key_defend = 1'b0;
    logic       hit = 1'b0;
    logic [7:0] frame_num;
    logic [7:0] character2_state;
    logic       attack_strike;
    logic       hit_blocked;
    logic       anim_done;

    int checks = 0;
    int passes = 0;

    // Pulse outputs captured in the Clk right after a tick.
    logic s_strike, s_blocked, s_done;

    iori_anim_ctrl dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .key_left         (key_left),
        .key_right        (key_right),
        .key_attack       (key_attack),
        .key_defend       (key_defend),
        .hit              (hit),
        .frame_num        (frame_num),
        .character2_state (character2_state),
        .attack_strike    (attack_strike),
        .hit_blocked      (hit_blocked),
        .anim_done        (anim_done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passes=%0d", checks, passes);
        $fatal(1, "watchdog");
    end

    // One frame tick; optionally a hit in the very Clk of the tick.
    task automatic do_tick(input logic with_hit);
        @(negedge Clk);
        frame_clk = 1'b1;
        hit       = with_hit;
        @(negedge Clk);
        frame_clk = 1'b0;
        hit       = 1'b0;
        s_strike  = attack_strike;
        s_blocked = hit_blocked;
        s_done    = anim_done;
        @(negedge Clk);
    endtask

    // Hit pulse between ticks.
    task automatic pulse_hit();
        @(negedge Clk);
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if ({character2_state, frame_num} !== 16'h0000)
            $display("FAIL reset_state: got st=%0d fr=%0d want st=0 fr=0", character2_state, frame_num);
        else passes++;
        checks++;
        if ({attack_strike, hit_blocked, anim_done} !== 3'b000)
            $display("FAIL reset_pulses: got %b want 000", {attack_strike, hit_blocked, anim_done});
        else passes++;
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    // Idle stand loop: frame advances every 6 ticks, wraps 8 -> 0.
    task automatic test_stand_loop();
        for (int k = 1; k <= 60; k++) begin
            do_tick(1'b0);
            checks++;
            if (character2_state !== 8'd0 || frame_num !== 8'((k / 6) % 9))
                $display("FAIL stand_loop k=%0d: got st=%0d fr=%0d want st=0 fr=%0d",
                         k, character2_state, frame_num, (k / 6) % 9);
            else passes++;
        end
    endtask

    task automatic test_move();
        key_left = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            do_tick(1'b0);
            checks++;
            if (character2_state !== 8'd2 || frame_num !== 8'd0)
                $display("FAIL movel k=%0d: got st=%0d fr=%0d want st=2 fr=0", k, character2_state, frame_num);
            else passes++;
        end
        key_right = 1'b1;
        do_tick(1'b0);
        checks++;
        if (character2_state !== 8'd0 || frame_num !== 8'd0)
            $display("FAIL both_keys: got st=%0d fr=%0d want st=0 fr=0", character2_state, frame_num);
        else passes++;
        key_left  = 1'b0;
        do_tick(1'b0);
        checks++;
        if (character2_state !== 8'd3 || frame_num !== 8'd0)
            $display("FAIL mover: got st=%0d fr=%0d want st=3 fr=0", character2_state, frame_num);
        else passes++;
        key_right = 1'b0;
        do_tick(1'b0);
        checks++;
        if (character2_state !== 8'd0)
            $display("FAIL release_keys: got st=%0d want st=0", character2_state);
        else passes++;
    endtask

    task automatic test_attack();
        key_attack = 1'b1;
        do_tick(1'b0);
        key_attack = 1'b0;
        checks++;
        if (character2_state !== 8'd1 || frame_num !== 8'd0)
            $display("FAIL attack_enter: got st=%0d fr=%0d want st=1 fr=0", character2_state, frame_num);
        else passes++;
        for (int k = 1; k <= 36; k++) begin
            // Keys pressed mid-attack must be ignored.
            key_left = (k == 10);
            do_tick(1'b0);
            if (k < 36) begin
                checks++;
                if (character2_state !== 8'd1 || frame_num !== 8'(k / 6))
                    $display("FAIL attack_run k=%0d: got st=%0d fr=%0d want st=1 fr=%0d",
                             k, character2_state, frame_num, k / 6);
                else passes++;
                checks++;
                if (s_strike !== (k == 18) || s_done !== 1'b0)
                    $display("FAIL attack_pulses k=%0d: got strike=%b done=%b want strike=%b done=0",
                             k, s_strike, s_done, (k == 18));
                else passes++;
            end else begin
                checks++;
                if (character2_state !== 8'd0 || frame_num !== 8'd0 || s_done !== 1'b1)
                    $display("FAIL attack_done: got st=%0d fr=%0d done=%b want st=0 fr=0 done=1",
                             character2_state, frame_num, s_done);
                else passes++;
            end
        end
        key_left = 1'b0;
        checks++;
        if (anim_done !== 1'b0)
            $display("FAIL done_width: got anim_done=%b want 0", anim_done);
        else passes++;
    endtask

    task automatic test_hit_attack();
        key_attack = 1'b1;
        do_tick(1'b0);
        key_attack = 1'b0;
        repeat (12) do_tick(1'b0);
        checks++;
        if (character2_state !== 8'd1 || frame_num !== 8'd2)
            $display("FAIL pre_hit: got st=%0d fr=%0d want st=1 fr=2", character2_state, frame_num);
        else passes++;
        pulse_hit();
        checks++;
        if (character2_state !== 8'd1)
            $display("FAIL hit_waits_tick: got st=%0d want st=1", character2_state);
        else passes++;
        do_tick(1'b0);
        checks++;
        if (character2_state !== 8'd5 || frame_num !== 8'd0)
            $display("FAIL hurt_enter: got st=%0d fr=%0d want st=5 fr=0", character2_state, frame_num);
        else passes++;
        for (int k = 1; k <= 30; k++) begin
            do_tick(1'b0);
            if (k == 29) begin
                checks++;
                if (character2_state !== 8'd5 || frame_num !== 8'd4 || s_done !== 1'b0)
                    $display("FAIL hurt_last: got st=%0d fr=%0d done=%b want st=5 fr=4 done=0",
                             character2_state, frame_num, s_done);
                else passes++;
            end
            if (k == 30) begin
                checks++;
                if (character2_state !== 8'd0 || frame_num !== 8'd0 || s_done !== 1'b1)
                    $display("FAIL hurt_done: got st=%0d fr=%0d done=%b want st=0 fr=0 done=1",
                             character2_state, frame_num, s_done);
                else passes++;
            end
        end
    endtask

    task automatic test_defense();
        key_defend = 1'b1;
        do_tick(1'b0);
        checks++;
        if (character2_state !== 8'd4 || frame_num !== 8'd0)
            $display("FAIL defend_enter: got st=%0d fr=%0d want st=4 fr=0", character2_state, frame_num);
        else passes++;
        pulse_hit();
        do_tick(1'b0);
        checks++;
        if (character2_state !== 8'd4 || frame_num !== 8'd0 || s_blocked !== 1'b1)
            $display("FAIL blocked: got st=%0d fr=%0d blk=%b want st=4 fr=0 blk=1",
                     character2_state, frame_num, s_blocked);
        else passes++;
        checks++;
        if (hit_blocked !== 1'b0)
            $display("FAIL blocked_width: got hit_blocked=%b want 0", hit_blocked);
        else passes++;
        // Hit coincident with the tick is consumed by it.
        do_tick(1'b1);
        checks++;
        if (character2_state !== 8'd4 || s_blocked !== 1'b1)
            $display("FAIL blocked_same_clk: got st=%0d blk=%b want st=4 blk=1", character2_state, s_blocked);
        else passes++;
        // Single-frame pose stays at frame 0 through a full hold period.
        for (int k = 1; k <= 7; k++) begin
            do_tick(1'b0);
            checks++;
            if (character2_state !== 8'd4 || frame_num !== 8'd0 || s_blocked !== 1'b0)
                $display("FAIL defend_hold k=%0d: got st=%0d fr=%0d blk=%b want st=4 fr=0 blk=0",
                         k, character2_state, frame_num, s_blocked);
            else passes++;
        end
        key_defend = 1'b0;
        do_tick(1'b0);
        checks++;
        if (character2_state !== 8'd0)
            $display("FAIL defend_release: got st=%0d want st=0", character2_state);
        else passes++;
    endtask

    task automatic test_reset_mid_hurt();
        pulse_hit();
        do_tick(1'b0);
        checks++;
        if (character2_state !== 8'd5 || frame_num !== 8'd0)
            $display("FAIL hurt2_enter: got st=%0d fr=%0d want st=5 fr=0", character2_state, frame_num);
        else passes++;
        for (int k = 1; k <= 18; k++) begin
            if (k == 8) pulse_hit();
            do_tick(1'b0);
            if (k == 8) begin
                checks++;
                if (character2_state !== 8'd5 || frame_num !== 8'd1)
                    $display("FAIL hurt_ignores_hit: got st=%0d fr=%0d want st=5 fr=1",
                             character2_state, frame_num);
                else passes++;
            end
        end
        checks++;
        if (character2_state !== 8'd5 || frame_num !== 8'd3)
            $display("FAIL hurt_frame3: got st=%0d fr=%0d want st=5 fr=3", character2_state, frame_num);
        else passes++;
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1;
        checks++;
        if ({character2_state, frame_num} !== 16'h0000)
            $display("FAIL async_reset: got st=%0d fr=%0d want st=0 fr=0", character2_state, frame_num);
        else passes++;
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (anim_done !== 1'b0)
                $display("FAIL reset_no_done: got anim_done=%b want 0", anim_done);
            else passes++;
        end
        Reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            do_tick(1'b0);
            checks++;
            if (character2_state !== 8'd0 || frame_num !== 8'(k / 6) || s_done !== 1'b0)
                $display("FAIL resume_stand k=%0d: got st=%0d fr=%0d done=%b want st=0 fr=%0d done=0",
                         k, character2_state, frame_num, s_done, k / 6);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_stand_loop();
        test_move();
        test_attack();
        test_hit_attack();
        test_defense();
        test_reset_mid_hurt();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
